// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues read-only fetches to Mem and queues words for decode.
// Optional FETCH_ALIGN_CHK_EN adds a sticky 'misalign' output and parks fetch on a misaligned redirect.
module fetch_unit #(
    parameter logic [11:0] RESET_PC = 12'h000,
    parameter int          MEM_LAT  = 1,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [11:0] Addrin,
    output logic        Memread,
    input  logic [31:0] BUS,
    input  logic        redir_valid,
    input  logic [11:0] redir_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
`ifdef FETCH_ALIGN_CHK_EN
    output logic        misalign,
`endif
    output logic [11:0] inst_pc
);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

    localparam logic [2:0] LAT = 3'(MEM_LAT);
    localparam logic [1:0] DEP = 2'(DEPTH);

    state_t      state_r;
    logic [11:0] pc_r;
    logic [11:0] addr_r;
    logic        rd_r;
    logic [2:0]  wcnt_r;
    logic [1:0]  cnt_r;
    logic        valid_r;
    logic [31:0] e0_word_r, e1_word_r;
    logic [11:0] e0_pc_r, e1_pc_r;

    logic        pop_s, push_s, issue_s, park_s;
    logic [1:0]  after_pop_s, cnt_next_s;
    logic [31:0] e0_word_s, e1_word_s;
    logic [11:0] e0_pc_s, e1_pc_s;
    logic [11:0] redir_tgt_s;

`ifdef FETCH_ALIGN_CHK_EN
    logic misalign_r;
    assign misalign = misalign_r;
    assign park_s   = misalign_r;
`else
    assign park_s   = 1'b0;
`endif

    assign redir_tgt_s = redir_pc & 12'hFFC;

    // Buffer occupancy bookkeeping and next-cycle issue decision (in-flight word counted as pushed)
    always_comb begin
        pop_s       = valid_r && inst_ready;
        push_s      = (state_r == REQ) && (wcnt_r == 3'd0);
        after_pop_s = cnt_r - {1'b0, pop_s};
        cnt_next_s  = after_pop_s + {1'b0, push_s};
        issue_s     = run && (cnt_next_s < DEP) && !park_s;
    end

    // Two-entry FIFO held as head/second slots so the head drives the outputs straight from flops
    always_comb begin
        e0_word_s = e0_word_r;
        e0_pc_s   = e0_pc_r;
        e1_word_s = e1_word_r;
        e1_pc_s   = e1_pc_r;
        if (pop_s) begin
            e0_word_s = e1_word_r;
            e0_pc_s   = e1_pc_r;
        end else begin
            e0_word_s = e0_word_r;
            e0_pc_s   = e0_pc_r;
        end
        if (push_s) begin
            if (after_pop_s == 2'd0) begin
                e0_word_s = BUS;
                e0_pc_s   = pc_r;
            end else begin
                e1_word_s = BUS;
                e1_pc_s   = pc_r;
            end
        end else begin
            e1_word_s = e1_word_r;
            e1_pc_s   = e1_pc_r;
        end
    end

    // Fetch FSM, bus strobes and buffer state; redirect outranks push, pop and issue
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            pc_r      <= RESET_PC;
            addr_r    <= RESET_PC;
            rd_r      <= 1'b0;
            wcnt_r    <= 3'd0;
            cnt_r     <= 2'd0;
            valid_r   <= 1'b0;
            e0_word_r <= 32'd0;
            e0_pc_r   <= 12'd0;
            e1_word_r <= 32'd0;
            e1_pc_r   <= 12'd0;
`ifdef FETCH_ALIGN_CHK_EN
            misalign_r <= 1'b0;
`endif
        end else if (redir_valid) begin
            state_r <= IDLE;
            pc_r    <= redir_tgt_s;
            addr_r  <= redir_tgt_s;
            rd_r    <= 1'b0;
            wcnt_r  <= 3'd0;
            cnt_r   <= 2'd0;
            valid_r <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
            misalign_r <= misalign_r | (redir_pc[1:0] != 2'b00);
`endif
        end else begin
            cnt_r     <= cnt_next_s;
            valid_r   <= (cnt_next_s != 2'd0);
            e0_word_r <= e0_word_s;
            e0_pc_r   <= e0_pc_s;
            e1_word_r <= e1_word_s;
            e1_pc_r   <= e1_pc_s;
            case (state_r)
                IDLE: begin
                    addr_r <= pc_r;
                    if (issue_s) begin
                        state_r <= REQ;
                        rd_r    <= 1'b1;
                        wcnt_r  <= LAT;
                    end else begin
                        rd_r    <= 1'b0;
                    end
                end
                REQ: begin
                    if (wcnt_r != 3'd0) begin
                        wcnt_r <= wcnt_r - 3'd1;
                    end else begin
                        // Word captured this edge; next fetch follows with no bubble
                        pc_r   <= pc_r + 12'd4;
                        addr_r <= pc_r + 12'd4;
                        if (issue_s) begin
                            wcnt_r <= LAT;
                        end else begin
                            state_r <= IDLE;
                            rd_r    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    rd_r    <= 1'b0;
                end
            endcase
        end
    end

    assign Addrin     = addr_r;
    assign Memread    = rd_r;
    assign inst_valid = valid_r;
    assign inst       = e0_word_r;
    assign inst_pc    = e0_pc_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: MEM_LAT=1 and MEM_LAT=3 instances share stimulus; a scoreboard expects the
// decode stream to be consecutive word addresses from each reset/redirect target, word = mem(pc).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, run, redir_valid, inst_ready;
    logic [11:0] redir_pc;
    logic [11:0] ad1, ad3, ip1, ip3;
    logic        rd1, rd3, iv1, iv3;
    logic [31:0] bus1, bus3, in1, in3;
`ifdef FETCH_ALIGN_CHK_EN
    logic        mis1, mis3;
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [11:0] a);
        return {a, 4'hA, a, 4'h5};
    endfunction

    assign bus1 = rd1 ? memw(ad1) : 32'hBAD0_0000;
    assign bus3 = rd3 ? memw(ad3) : 32'hBAD0_0000;

    fetch_unit #(.RESET_PC(12'h000), .MEM_LAT(1), .DEPTH(2)) u1 (
        .clk(clk), .rst(rst), .run(run), .Addrin(ad1), .Memread(rd1), .BUS(bus1),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .inst_valid(iv1),
        .inst_ready(inst_ready), .inst(in1),
`ifdef FETCH_ALIGN_CHK_EN
        .misalign(mis1),
`endif
        .inst_pc(ip1));

    fetch_unit #(.RESET_PC(12'h000), .MEM_LAT(3), .DEPTH(2)) u3 (
        .clk(clk), .rst(rst), .run(run), .Addrin(ad3), .Memread(rd3), .BUS(bus3),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .inst_valid(iv3),
        .inst_ready(inst_ready), .inst(in3),
`ifdef FETCH_ALIGN_CHK_EN
        .misalign(mis3),
`endif
        .inst_pc(ip3));

    typedef struct packed {
        logic [11:0] pc;
        logic [31:0] w;
    } exp_t;

    exp_t        q1[$];
    exp_t        q3[$];
    exp_t        e1v, e3v;
    logic [11:0] tail1, tail3;
    int          n_chk = 0;
    int          n_pass = 0;
    int          hs1 = 0;
    int          hs3 = 0;
    int          wlen[2];
    logic [11:0] wad[2];
    logic        wrd[2];
    logic        win_en = 1'b0;
    logic        found;
    logic [11:0] t1_addr[6] = '{12'h000, 12'h000, 12'h004, 12'h004, 12'h008, 12'h008};
    logic        t1_val[3]  = '{1'b0, 1'b0, 1'b1};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic top_up();
        while (q1.size() < 4) begin
            q1.push_back(exp_t'{tail1, memw(tail1)});
            tail1 = tail1 + 12'd4;
        end
        while (q3.size() < 4) begin
            q3.push_back(exp_t'{tail3, memw(tail3)});
            tail3 = tail3 + 12'd4;
        end
    endtask

    task automatic restart(input logic [11:0] pc);
        q1.delete();
        q3.delete();
        tail1 = pc;
        tail3 = pc;
        top_up();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        top_up();
    endtask

    task automatic do_reset();
        inst_ready = 1'b0;
        redir_valid = 1'b0;
        rst = 1'b1;
        restart(12'h000);
        step();
        rst = 1'b0;
    endtask

    task automatic win_step(input int k, input logic rd, input logic [11:0] a, input int lat);
        if (wrd[k] && (!rd || a != wad[k]) && win_en)
            check($sformatf("memread_hold_lat%0d", lat), 32'(wlen[k]), 32'(lat + 1));
        if (rd) wlen[k] = (wrd[k] && a == wad[k]) ? wlen[k] + 1 : 1;
        else wlen[k] = 0;
        wrd[k] = rd;
        wad[k] = a;
    endtask

    // Monitor: pop the scoreboard on every decode handshake and track Memread windows
    always @(negedge clk) begin
        if (iv1 && inst_ready) begin
            hs1++;
            if (q1.size() == 0) begin
                n_chk++;
                $display("FAIL sb_lat1: handshake pc %h with nothing expected", ip1);
            end else begin
                e1v = q1.pop_front();
                check("sb_lat1_pc", 32'(ip1), 32'(e1v.pc));
                check("sb_lat1_word", in1, e1v.w);
            end
        end
        if (iv3 && inst_ready) begin
            hs3++;
            if (q3.size() == 0) begin
                n_chk++;
                $display("FAIL sb_lat3: handshake pc %h with nothing expected", ip3);
            end else begin
                e3v = q3.pop_front();
                check("sb_lat3_pc", 32'(ip3), 32'(e3v.pc));
                check("sb_lat3_word", in3, e3v.w);
            end
        end
        win_step(0, rd1, ad1, 1);
        win_step(1, rd3, ad3, 3);
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            wlen[k] = 0; wad[k] = 12'h000; wrd[k] = 1'b0;
        end
        rst = 1'b1; run = 1'b0; redir_valid = 1'b0; redir_pc = 12'h000; inst_ready = 1'b0;
        restart(12'h000);
        step();
        step();
        @(negedge clk);
        check("rst_memread", 32'(rd1), 32'd0);
        check("rst_addrin", 32'(ad1), 32'h000);
        check("rst_inst_valid", 32'(iv1), 32'd0);
        check("rst_inst", in1, 32'd0);
        check("rst_inst_pc", 32'(ip1), 32'd0);
        check("rst_memread_lat3", 32'(rd3), 32'd0);

        // T1: address sequence and first-valid latency
        step();
        rst = 1'b0; run = 1'b1; inst_ready = 1'b1;
        restart(12'h000);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("t1_addrin_%0d", i), 32'(ad1), 32'(t1_addr[i]));
            if (i < 3) check($sformatf("t1_valid_%0d", i), 32'(iv1), 32'(t1_val[i]));
        end

        // T2: stalled decode fills the buffer and freezes fetch
        step();
        do_reset();
        run = 1'b1;
        repeat (10) step();
        @(negedge clk);
        check("t2_full_memread", 32'(rd1), 32'd0);
        check("t2_full_addrin", 32'(ad1), 32'h008);
        check("t2_full_valid", 32'(iv1), 32'd1);
        check("t2_full_head", 32'(ip1), 32'h000);
        step();
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        @(negedge clk);
        check("t2_refetch_memread", 32'(rd1), 32'd1);
        check("t2_refetch_addrin", 32'(ad1), 32'h008);
        check("t2_refetch_head", 32'(ip1), 32'h004);
        repeat (6) step();
        @(negedge clk);
        check("t2_refull_memread", 32'(rd1), 32'd0);
        check("t2_refull_addrin", 32'(ad1), 32'h00C);

        // T3: redirect while fetching address 4
        step();
        do_reset();
        run = 1'b1; inst_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (rd1 && ad1 == 12'h004) found = 1'b1;
        end
        check("t3_reached_addr4", 32'(found), 32'd1);
        @(posedge clk); #1;
        redir_valid = 1'b1; redir_pc = 12'h040; inst_ready = 1'b0;
        restart(12'h040);
        step();
        redir_valid = 1'b0; inst_ready = 1'b1;
        @(negedge clk);
        check("t3_gap_memread", 32'(rd1), 32'd0);
        check("t3_gap_valid", 32'(iv1), 32'd0);
        check("t3_gap_memread_lat3", 32'(rd3), 32'd0);
        step();
        @(negedge clk);
        check("t3_issue_memread", 32'(rd1), 32'd1);
        check("t3_issue_addrin", 32'(ad1), 32'h040);
        check("t3_issue_addrin_lat3", 32'(ad3), 32'h040);
        repeat (10) step();

        // T4: PC wrap from FFC to 000
        redir_valid = 1'b1; redir_pc = 12'hFFC; inst_ready = 1'b0;
        restart(12'hFFC);
        step();
        redir_valid = 1'b0; inst_ready = 1'b1;
        repeat (14) step();

        // T6: misaligned redirect target
        redir_valid = 1'b1; redir_pc = 12'h042; inst_ready = 1'b0;
        restart(12'h040);
        step();
        redir_valid = 1'b0; inst_ready = 1'b1;
`ifdef FETCH_ALIGN_CHK_EN
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t6_parked_memread", 32'(rd1), 32'd0);
            check("t6_parked_valid", 32'(iv1), 32'd0);
            check("t6_misalign", 32'(mis1), 32'd1);
            check("t6_misalign_lat3", 32'(mis3), 32'd1);
            step();
        end
        do_reset();
        @(negedge clk);
        check("t6_misalign_cleared", 32'(mis1), 32'd0);
`else
        @(negedge clk);
        check("t6_gap_memread", 32'(rd1), 32'd0);
        step();
        @(negedge clk);
        check("t6_issue_addrin", 32'(ad1), 32'h040);
        check("t6_issue_memread", 32'(rd1), 32'd1);
        repeat (8) step();
`endif

        // T5: reset mid-fetch with a word buffered, then clean run with hold-time checks
        do_reset();
        run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (rd1 && iv1) found = 1'b1;
        end
        check("t5_reached_busy", 32'(found), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        restart(12'h000);
        step();
        rst = 1'b0; inst_ready = 1'b1; win_en = 1'b1;
        @(negedge clk);
        check("t5_rst_memread", 32'(rd1), 32'd0);
        check("t5_rst_addrin", 32'(ad1), 32'h000);
        check("t5_rst_valid", 32'(iv1), 32'd0);
        check("t5_rst_inst", in1, 32'd0);
        check("t5_rst_inst_pc", 32'(ip1), 32'd0);
        check("t5_rst_valid_lat3", 32'(iv3), 32'd0);
        step();
        @(negedge clk);
        check("t5_first_addrin", 32'(ad1), 32'h000);
        check("t5_first_memread", 32'(rd1), 32'd1);
        check("t5_first_addrin_lat3", 32'(ad3), 32'h000);
        repeat (40) step();
        win_en = 1'b0;

        // Randomised traffic: run, decode back-pressure and aligned redirects
        for (int i = 0; i < 300; i++) begin
            run = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 24) == 0) begin
                redir_valid = 1'b1;
                redir_pc = 12'($urandom) & 12'hFFC;
                inst_ready = 1'b0;
                restart(redir_pc);
            end else begin
                redir_valid = 1'b0;
                inst_ready = ($urandom_range(0, 2) != 0);
            end
            step();
        end
        redir_valid = 1'b0; inst_ready = 1'b1; run = 1'b0;
        repeat (20) step();
        check("handshakes_lat1", 32'(hs1 > 40), 32'd1);
        check("handshakes_lat3", 32'(hs3 > 15), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
